// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cursor_ctrl
//  Purpose  : Button debounce, tear-free 16x16 cursor movement with
//             hold-to-repeat, and reveal/flag command issue on valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module cursor_ctrl #(
    parameter int GRID_W          = 16,
    parameter int GRID_H          = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_reveal,
    input  logic       btn_flag,
    input  logic       frame_start,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       cmd_valid,
    output logic       cmd_op,
    output logic [3:0] cmd_x,
    output logic [3:0] cmd_y,
    input  logic       cmd_ready
);

    localparam int c_MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAX_CNT = (c_MAX_A > REPEAT_RATE) ? c_MAX_A : REPEAT_RATE;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT) + 1;

    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REP_DELAY = c_CNT_W'(REPEAT_DELAY);
    localparam logic [c_CNT_W-1:0] c_REP_RATE  = c_CNT_W'(REPEAT_RATE);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_X_LAST    = 4'(GRID_W - 1);
    localparam logic [3:0]         c_Y_LAST    = 4'(GRID_H - 1);

    localparam int c_UP     = 0;
    localparam int c_DOWN   = 1;
    localparam int c_LEFT   = 2;
    localparam int c_RIGHT  = 3;
    localparam int c_REVEAL = 4;
    localparam int c_FLAG   = 5;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    logic [5:0] w_btn_raw;
    logic [5:0] w_level;
    logic [5:0] w_press;
    logic [3:0] w_move_req;
    logic [3:0] r_pend;
    logic [3:0] r_cursor_x;
    logic [3:0] r_cursor_y;
    logic [3:0] w_next_x;
    logic [3:0] w_next_y;
    state_t     r_state;
    logic       r_cmd_valid;
    logic       r_cmd_op;
    logic [3:0] r_cmd_x;
    logic [3:0] r_cmd_y;

    assign w_btn_raw = {btn_flag, btn_reveal, btn_right, btn_left, btn_down, btn_up};

    // Level flips only after the synchronized input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; press marks a rising flip.
    for (genvar i = 0; i < 6; i++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_press;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[i];
                r_sync2 <= r_sync1;
                r_press <= 1'b0;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end

        assign w_level[i] = r_level;
        assign w_press[i] = r_press;
    end

    // Counter reads k in the k-th cycle after the press (or after the last
    // repeat), so a hit lands exactly REPEAT_DELAY / REPEAT_RATE cycles later.
    for (genvar i = 0; i < 4; i++) begin : g_dir
        logic               r_first;
        logic [c_CNT_W-1:0] r_rcnt;
        logic               w_hit;

        assign w_hit = w_level[i] & ~w_press[i] &
                       (r_first ? (r_rcnt == c_REP_DELAY) : (r_rcnt == c_REP_RATE));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_first <= 1'b1;
                r_rcnt  <= '0;
            end else if (!w_level[i]) begin
                r_first <= 1'b1;
                r_rcnt  <= '0;
            end else if (w_press[i]) begin
                r_first <= 1'b1;
                r_rcnt  <= c_CNT_ONE;
            end else if (w_hit) begin
                r_first <= 1'b0;
                r_rcnt  <= c_CNT_ONE;
            end else begin
                r_rcnt <= r_rcnt + c_CNT_ONE;
            end
        end

        assign w_move_req[i] = w_press[i] | w_hit;
    end

    always_comb begin
        w_next_x = r_cursor_x;
        w_next_y = r_cursor_y;
        if (r_pend[c_RIGHT] && !r_pend[c_LEFT]) begin
            w_next_x = (r_cursor_x == c_X_LAST) ? 4'd0 : r_cursor_x + 4'd1;
        end else if (r_pend[c_LEFT] && !r_pend[c_RIGHT]) begin
            w_next_x = (r_cursor_x == 4'd0) ? c_X_LAST : r_cursor_x - 4'd1;
        end
        if (r_pend[c_DOWN] && !r_pend[c_UP]) begin
            w_next_y = (r_cursor_y == c_Y_LAST) ? 4'd0 : r_cursor_y + 4'd1;
        end else if (r_pend[c_UP] && !r_pend[c_DOWN]) begin
            w_next_y = (r_cursor_y == 4'd0) ? c_Y_LAST : r_cursor_y - 4'd1;
        end
    end

    // Requests coinciding with frame_start become the next frame's pending set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= '0;
            r_cursor_x <= 4'd0;
            r_cursor_y <= 4'd0;
        end else if (frame_start) begin
            r_cursor_x <= w_next_x;
            r_cursor_y <= w_next_y;
            r_pend     <= w_move_req;
        end else begin
            r_pend <= r_pend | w_move_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 1'b0;
            r_cmd_x     <= 4'd0;
            r_cmd_y     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press[c_REVEAL] || w_press[c_FLAG]) begin
                        r_state     <= S_ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= ~w_press[c_REVEAL];
                        r_cmd_x     <= r_cursor_x;
                        r_cmd_y     <= r_cursor_y;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_state     <= S_IDLE;
                        r_cmd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cursor_x  = r_cursor_x;
    assign cursor_y  = r_cursor_y;
    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_x     = r_cmd_x;
    assign cmd_y     = r_cmd_y;

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cursor_ctrl
//  Purpose  : Directed + randomized bench for cursor_ctrl against a
//             cycle-level behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cursor_ctrl;

    localparam int DB   = 4;
    localparam int RD   = 20;
    localparam int RR   = 8;
    localparam int GW   = 16;
    localparam int GH   = 16;
    localparam int NLOG = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       frame_start;
    logic       cmd_ready;
    logic [3:0] cursor_x, cursor_y, cmd_x, cmd_y;
    logic       cmd_valid, cmd_op;

    always #5 clk = ~clk;

    cursor_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
        .btn_reveal(btn[4]), .btn_flag(btn[5]),
        .frame_start(frame_start),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_ready(cmd_ready)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw samples are logged per clock edge; a button's
    // level flips when the D samples seen through the 2-cycle synchronizer
    // all disagree with it. Repeats are timed arithmetically from the press.
    logic [5:0] rawlog [NLOG];
    int n_edge   = 0;
    int rst_edge = 1;
    int cyc      = 0;
    bit [5:0] m_lvl, m_press;
    bit [3:0] m_held, m_pend;
    int m_p [4];
    int m_cx, m_cy, m_x, m_y;
    bit m_busy, m_op;

    function automatic bit sample(input int b, input int k);
        if (k < rst_edge) return 1'b0;
        return rawlog[k][b];
    endfunction

    task automatic model_reset();
        m_lvl = '0; m_press = '0; m_held = '0; m_pend = '0;
        m_cx = 0; m_cy = 0; m_x = 0; m_y = 0;
        m_busy = 1'b0; m_op = 1'b0;
    endtask

    task automatic model_step();
        bit [5:0] req;
        bit [5:0] pnext;
        bit       all_diff;
        int       d, dx, dy;
        n_edge++;
        rawlog[n_edge] = btn;
        if (!rst) begin
            model_reset();
            rst_edge = n_edge + 1;
        end else begin
            req = '0;
            for (int b = 0; b < 4; b++) begin
                if (!m_lvl[b]) m_held[b] = 1'b0;
                if (m_press[b]) begin
                    req[b] = 1'b1; m_p[b] = n_edge; m_held[b] = 1'b1;
                end else if (m_held[b]) begin
                    d = n_edge - m_p[b];
                    if (d == RD || (d > RD && (d - RD) % RR == 0)) req[b] = 1'b1;
                end
            end
            if (!m_busy) begin
                if (m_press[4] || m_press[5]) begin
                    m_busy = 1'b1; m_op = !m_press[4]; m_x = m_cx; m_y = m_cy;
                end
            end else if (cmd_ready) begin
                m_busy = 1'b0;
            end
            if (frame_start) begin
                dx = int'(m_pend[3] && !m_pend[2]) - int'(m_pend[2] && !m_pend[3]);
                dy = int'(m_pend[1] && !m_pend[0]) - int'(m_pend[0] && !m_pend[1]);
                m_cx = (m_cx + dx + GW) % GW;
                m_cy = (m_cy + dy + GH) % GH;
                m_pend = req[3:0];
            end else begin
                m_pend = m_pend | req[3:0];
            end
            pnext = '0;
            for (int b = 0; b < 6; b++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DB + 1; j++)
                    if (sample(b, n_edge - j) == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[b] = !m_lvl[b];
                    pnext[b] = m_lvl[b];
                end
            end
            m_press = pnext;
        end
    endtask

    task automatic compare_all();
        check("cursor_x", cursor_x, m_cx);
        check("cursor_y", cursor_y, m_cy);
        check("cmd_valid", cmd_valid, m_busy);
        check("cmd_op", cmd_op, m_op);
        check("cmd_x", cmd_x, m_x);
        check("cmd_y", cmd_y, m_y);
    endtask

    task automatic tick();
        frame_start = (cyc % 10 == 9);
        cyc++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic [5:0] m);
        btn = btn | m;
        repeat (10) tick();
        btn = btn & ~m;
        repeat (14) tick();
    endtask

    task automatic goto_cell(input int tx, input int ty);
        for (int k = 0; k < GW && m_cx != tx; k++) press(6'b001000);
        for (int k = 0; k < GH && m_cy != ty; k++) press(6'b000010);
    endtask

    task automatic async_reset();
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        check("arst_x", cursor_x, 0);
        check("arst_y", cursor_y, 0);
        check("arst_valid", cmd_valid, 0);
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
    endtask

    initial begin
        bit [5:0] tgt;
        rst = 1'b0; btn = '0; frame_start = 1'b0; cmd_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        check("rst_x", cursor_x, 0);
        check("rst_valid", cmd_valid, 0);

        // Bouncing right button, then a clean hold: a single step only.
        for (int k = 0; k < 30; k++) begin
            btn[3] = (k % 4) < 2;
            tick();
        end
        btn[3] = 1'b1;
        repeat (12) tick();
        btn[3] = 1'b0;
        repeat (16) tick();
        check("dbnc_x", cursor_x, 1);

        press(6'b000100);
        press(6'b000100);
        check("wrap_l_x", cursor_x, 15);
        check("wrap_l_y", cursor_y, 0);
        press(6'b001010);
        check("wrap_rd_x", cursor_x, 0);
        check("wrap_rd_y", cursor_y, 1);
        press(6'b000100);
        check("wrap_l2_x", cursor_x, 15);
        press(6'b001100);
        check("cancel_x", cursor_x, 15);

        goto_cell(0, 5);
        btn[0] = 1'b1;
        repeat (60) tick();
        btn[0] = 1'b0;
        repeat (24) tick();

        goto_cell(3, 7);
        cmd_ready = 1'b0;
        btn[4] = 1'b1;
        repeat (10) tick();
        btn[4] = 1'b0;
        check("hs_valid", cmd_valid, 1);
        check("hs_op", cmd_op, 0);
        check("hs_x", cmd_x, 3);
        check("hs_y", cmd_y, 7);
        press(6'b001000);
        check("hs_cur_x", cursor_x, 4);
        check("hs_hold_x", cmd_x, 3);
        press(6'b100000);
        check("hs_flag_op", cmd_op, 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("hs_drop", cmd_valid, 0);
        repeat (30) tick();
        check("hs_no_second", cmd_valid, 0);

        press(6'b110000);
        check("coll_valid", cmd_valid, 1);
        check("coll_op", cmd_op, 0);
        async_reset();
        repeat (5) tick();

        tgt = '0;
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 47) == 0) tgt[b] = ~tgt[b];
                btn[b] = ($urandom_range(0, 11) == 0) ? ~tgt[b] : tgt[b];
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            if (c == 1200) async_reset();
            tick();
        end
        btn = '0;
        repeat (30) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
